// File: rtl/traffic_pkg.sv
// Shared types and constants for the two-approach intersection phase scheduler.
package traffic_pkg;

  localparam int LIGHT_W = 2;

  localparam logic APP0 = 1'b0;
  localparam logic APP1 = 1'b1;

  typedef enum logic [1:0] {
    ST_GREEN  = 2'd0,
    ST_YELLOW = 2'd1,
    ST_CLEAR  = 2'd2,
    ST_WALK   = 2'd3
  } phase_t;

  function automatic int max_of(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/phase_timer.sv
// Phase timer: up-counter with synchronous clear, optional saturation and terminal compare.
// Latency: count updates one edge after clr/advance; at_term is combinational on count.
// Backpressure: none, free-running once out of reset.
module phase_timer #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         sat_en,
  input  logic [W-1:0] sat_val,
  input  logic [W-1:0] term_val,
  output logic [W-1:0] count,
  output logic         at_term
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (!(sat_en && (count == sat_val))) begin
      count <= count + W'(1);
    end
  end

  assign at_term = (count == term_val);

endmodule

// File: rtl/traffic_phase_sched.sv
// Demand-driven phase scheduler: green/yellow/all-red/walk sequencing for two approaches.
// Latency: phase decisions take effect on the edge where the condition holds; outputs are Moore.
// Backpressure: none; car_req is level-sampled, ped_req is latched until walk is served.
module traffic_phase_sched
  import traffic_pkg::*;
#(
  parameter int MIN_GREEN = 4,
  parameter int MAX_GREEN = 12,
  parameter int YELLOW    = 2,
  parameter int ALL_RED   = 1,
  parameter int WALK      = 6
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [LIGHT_W-1:0] car_req,
  input  logic               ped_req,
  output logic [LIGHT_W-1:0] red_light,
  output logic [LIGHT_W-1:0] yellow_light,
  output logic [LIGHT_W-1:0] green_light,
  output logic               walk
);

  localparam int MAXP = max_of(max_of(max_of(MIN_GREEN, MAX_GREEN), max_of(YELLOW, ALL_RED)), WALK);
  localparam int TW   = $clog2(MAXP) + 1;

  localparam logic [TW-1:0] T_MING = TW'(MIN_GREEN - 1);
  localparam logic [TW-1:0] T_MAXG = TW'(MAX_GREEN - 1);
  localparam logic [TW-1:0] T_YEL  = TW'(YELLOW - 1);
  localparam logic [TW-1:0] T_AR   = TW'(ALL_RED - 1);
  localparam logic [TW-1:0] T_WALK = TW'(WALK - 1);

  phase_t          state_q, state_d;
  logic            owner_q, owner_d;
  logic            ped_pend_q;
  logic [TW-1:0]   timer;
  logic [TW-1:0]   term_val;
  logic            at_term;
  logic            timer_clr;
  logic            compete;
  logic            enter_walk;

  phase_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .clr      (timer_clr),
    .sat_en   (state_q == ST_GREEN),
    .sat_val  (T_MAXG),
    .term_val (term_val),
    .count    (timer),
    .at_term  (at_term)
  );

  assign compete = car_req[~owner_q] | ped_pend_q;

  // Green ends on gap-out (own approach idle) or max-out, only once contested.
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    term_val = T_MAXG;
    case (state_q)
      ST_GREEN: begin
        term_val = T_MAXG;
        if ((timer >= T_MING) && compete && (!car_req[owner_q] || at_term))
          state_d = ST_YELLOW;
      end
      ST_YELLOW: begin
        term_val = T_YEL;
        if (at_term)
          state_d = ST_CLEAR;
      end
      ST_CLEAR: begin
        term_val = T_AR;
        if (at_term) begin
          if (ped_pend_q) begin
            state_d = ST_WALK;
          end else begin
            state_d = ST_GREEN;
            owner_d = ~owner_q;
          end
        end
      end
      ST_WALK: begin
        term_val = T_WALK;
        if (at_term) begin
          state_d = ST_GREEN;
          owner_d = car_req[~owner_q] ? ~owner_q : owner_q;
        end
      end
      default: begin
        state_d = ST_GREEN;
      end
    endcase
  end

  assign timer_clr  = (state_d != state_q);
  assign enter_walk = (state_d == ST_WALK) && (state_q != ST_WALK);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_GREEN;
      owner_q    <= APP0;
      ped_pend_q <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      // Entry into walk wins over a same-cycle press, absorbing it.
      if (enter_walk)
        ped_pend_q <= 1'b0;
      else if (ped_req && (state_q != ST_WALK))
        ped_pend_q <= 1'b1;
    end
  end

  always_comb begin
    red_light    = '1;
    yellow_light = '0;
    green_light  = '0;
    walk         = 1'b0;
    case (state_q)
      ST_GREEN: begin
        green_light[owner_q] = 1'b1;
        red_light[owner_q]   = 1'b0;
      end
      ST_YELLOW: begin
        yellow_light[owner_q] = 1'b1;
        red_light[owner_q]    = 1'b0;
      end
      ST_WALK: begin
        walk = 1'b1;
      end
      default: begin
        walk = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_traffic_phase_sched.sv
// Bench for traffic_phase_sched: directed scenarios plus random demand against a phase-age model.
module tb_traffic_phase_sched;

  localparam int MIN_G = 4;
  localparam int MAX_G = 12;
  localparam int YEL   = 2;
  localparam int AR    = 1;
  localparam int WLK   = 6;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [1:0] car_req = 2'b00;
  logic       ped_req = 1'b0;
  logic [1:0] red_light, yellow_light, green_light;
  logic       walk;

  int total = 0;
  int bad   = 0;

  // Model: phase 0=green 1=yellow 2=all-red 3=walk; age = cycles already spent in the phase.
  int m_ph;
  bit m_own;
  int m_age;
  bit m_ped;

  localparam logic [6:0] RST_OUT = {2'b10, 2'b00, 2'b01, 1'b0};

  traffic_phase_sched #(
    .MIN_GREEN(MIN_G), .MAX_GREEN(MAX_G), .YELLOW(YEL), .ALL_RED(AR), .WALK(WLK)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .car_req      (car_req),
    .ped_req      (ped_req),
    .red_light    (red_light),
    .yellow_light (yellow_light),
    .green_light  (green_light),
    .walk         (walk)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] obs();
    return {red_light, yellow_light, green_light, walk};
  endfunction

  function automatic logic [6:0] exp_out();
    logic [1:0] r, y, g;
    r = 2'b00; y = 2'b00; g = 2'b00;
    for (int i = 0; i < 2; i++) begin
      if (i == int'(m_own) && m_ph == 0)      g[i] = 1'b1;
      else if (i == int'(m_own) && m_ph == 1) y[i] = 1'b1;
      else                                    r[i] = 1'b1;
    end
    return {r, y, g, (m_ph == 3)};
  endfunction

  function automatic bit inv_ok();
    bit ok;
    ok = (green_light != 2'b11);
    for (int i = 0; i < 2; i++)
      ok = ok && ((int'(red_light[i]) + int'(yellow_light[i]) + int'(green_light[i])) == 1);
    if (walk) ok = ok && (red_light == 2'b11);
    return ok;
  endfunction

  task automatic model_reset();
    m_ph = 0; m_own = 1'b0; m_age = 0; m_ped = 1'b0;
  endtask

  task automatic model_step(input logic [1:0] car, input logic ped);
    int nph;
    bit nown;
    nph  = m_ph;
    nown = m_own;
    case (m_ph)
      0: if (m_age + 1 >= MIN_G && (car[!m_own] || m_ped) && (!car[m_own] || m_age + 1 >= MAX_G)) nph = 1;
      1: if (m_age + 1 == YEL) nph = 2;
      2: if (m_age + 1 == AR) begin
           if (m_ped) nph = 3;
           else begin nph = 0; nown = !m_own; end
         end
      default: if (m_age + 1 == WLK) begin
           nph = 0;
           if (car[!m_own]) nown = !m_own;
         end
    endcase
    if (nph == 3 && m_ph != 3)  m_ped = 1'b0;
    else if (ped && m_ph != 3)  m_ped = 1'b1;
    m_age = (nph != m_ph) ? 0 : m_age + 1;
    m_ph  = nph;
    m_own = nown;
  endtask

  // Called at a negedge; returns at the following negedge with the model advanced.
  task automatic run_cycle(input logic [1:0] car, input logic ped);
    car_req = car;
    ped_req = ped;
    @(posedge clk);
    model_step(car, ped);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0; car_req = 2'b00; ped_req = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    reset = 1'b0; car_req = 2'b11; ped_req = 1'b1;
    repeat (3) begin
      @(negedge clk);
      total++;
      if (obs() !== RST_OUT) begin
        bad++; $display("FAIL reset_hold got=%b exp=%b", obs(), RST_OUT);
      end
    end
    reset = 1'b1; car_req = 2'b00; ped_req = 1'b0;
    model_reset();
  endtask

  task automatic test_idle();
    for (int k = 0; k < 50; k++) begin
      run_cycle(2'b00, 1'b0);
      total++;
      if (red_light !== 2'b10 || obs() !== exp_out()) begin
        bad++; $display("FAIL idle_hold cyc=%0d got=%b exp=%b", k, obs(), exp_out());
      end
    end
  endtask

  task automatic test_gap_out();
    logic [1:0] g_tab [8];
    logic [1:0] y_tab [8];
    g_tab = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 2'b10};
    y_tab = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b01, 2'b00, 2'b00};
    do_reset();
    car_req = 2'b10;
    for (int k = 0; k < 8; k++) begin
      if (k > 0) run_cycle(2'b10, 1'b0);
      total++;
      if (green_light !== g_tab[k] || yellow_light !== y_tab[k]) begin
        bad++; $display("FAIL gap_seq s=%0d got g=%b y=%b exp g=%b y=%b",
                        k, green_light, yellow_light, g_tab[k], y_tab[k]);
      end
    end
  endtask

  task automatic test_max_out();
    int run;
    int ends;
    do_reset();
    run  = 1;
    ends = 0;
    for (int k = 0; k < 70; k++) begin
      run_cycle(2'b11, 1'b0);
      total++;
      if (obs() !== exp_out() || !inv_ok()) begin
        bad++; $display("FAIL max_model cyc=%0d got=%b exp=%b", k, obs(), exp_out());
      end
      if (green_light != 2'b00) begin
        run++;
      end else if (run > 0) begin
        ends++;
        total++;
        if (run != MAX_G) begin
          bad++; $display("FAIL max_len got=%0d exp=%0d", run, MAX_G);
        end
        run = 0;
      end
    end
    total++;
    if (ends < 4) begin
      bad++; $display("FAIL max_alternations got=%0d exp>=4", ends);
    end
  endtask

  task automatic test_ped_walk();
    int walks;
    int walk_starts;
    logic prev_walk;
    do_reset();
    walks = 0; walk_starts = 0; prev_walk = 1'b0;
    for (int k = 0; k < 30; k++) begin
      run_cycle(2'b00, (k == 2) || (walk && walks == 2));
      if (walk) walks++;
      if (walk && !prev_walk) walk_starts++;
      prev_walk = walk;
      total++;
      if (obs() !== exp_out() || !inv_ok()) begin
        bad++; $display("FAIL ped_model cyc=%0d got=%b exp=%b", k, obs(), exp_out());
      end
      if (k == 3) begin
        total++;
        if (yellow_light !== 2'b01) begin
          bad++; $display("FAIL ped_green_end got=%b exp=01", yellow_light);
        end
      end
    end
    total++;
    if (walks != WLK || walk_starts != 1) begin
      bad++; $display("FAIL ped_walk_count got=%0d/%0d exp=%0d/1", walks, walk_starts, WLK);
    end
    total++;
    if (green_light !== 2'b01) begin
      bad++; $display("FAIL ped_return got=%b exp=01", green_light);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int k = 0; k < 4; k++) run_cycle(2'b10, k == 1);
    total++;
    if (yellow_light !== 2'b01) begin
      bad++; $display("FAIL async_pre_yellow got=%b exp=01", yellow_light);
    end
    #2 reset = 1'b0;
    #1;
    total++;
    if (obs() !== RST_OUT) begin
      bad++; $display("FAIL async_reset got=%b exp=%b", obs(), RST_OUT);
    end
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    for (int k = 0; k < 25; k++) begin
      run_cycle(2'b00, 1'b0);
      total++;
      if (obs() !== exp_out() || obs() !== RST_OUT) begin
        bad++; $display("FAIL async_resume cyc=%0d got=%b exp=%b", k, obs(), exp_out());
      end
    end
  endtask

  task automatic test_random();
    logic [1:0] car;
    logic ped;
    do_reset();
    for (int k = 0; k < 800; k++) begin
      if ($urandom_range(0, 7) == 0) car = 2'($urandom_range(0, 3));
      else car = car_req;
      ped = ($urandom_range(0, 19) == 0);
      run_cycle(car, ped);
      total++;
      if (obs() !== exp_out() || !inv_ok()) begin
        bad++; $display("FAIL random_model cyc=%0d got=%b exp=%b", k, obs(), exp_out());
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_idle();
    test_gap_out();
    test_max_out();
    test_ped_walk();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/traffic_phase_sched.md
# traffic_phase_sched

Phase scheduler for the two-approach intersection lights (approach 0 and approach 1). It decides which approach owns green, when a green ends, and when a pedestrian walk phase is inserted. Green timing uses vehicle-sensor demand with minimum/maximum green limits. It drives the per-approach `red_light`/`yellow_light`/`green_light` vectors (bit i = approach i) plus a `walk` output, and replaces the fixed-cycle sequencing of the existing light block.

## Interface
- `MIN_GREEN`, 4, minimum green duration in cycles (≥1)
- `MAX_GREEN`, 12, green duration after which a contested green is forced to end (≥ MIN_GREEN)
- `YELLOW`, 2, yellow duration in cycles (≥1)
- `ALL_RED`, 1, all-red clearance after yellow, in cycles (≥1)
- `WALK`, 6, pedestrian walk duration in cycles (≥1)

- `clk`  in  1  single clock, rising edge
- `reset`  in  1  asynchronous, active-low reset (0 = reset)
- `car_req`  in  2  level vehicle demand per approach, sampled each cycle
- `ped_req`  in  1  pedestrian button, single-cycle or level; latched internally
- `red_light`  out  2  red per approach
- `yellow_light`  out  2  yellow per approach
- `green_light`  out  2  green per approach
- `walk`  out  1  pedestrian walk indication

## Operation
- State registers: FSM state {GREEN, YELLOW, CLEAR, WALK}, `owner` (1 bit), `timer`, `ped_pend`.
  - `timer` clears on every state entry and counts up each cycle.
  - In GREEN, `timer` saturates at MAX_GREEN-1.
- Competing demand in GREEN = `car_req[~owner] | ped_pend`.
- GREEN → YELLOW when `timer ≥ MIN_GREEN-1` AND competing demand AND (`car_req[owner]==0` OR `timer==MAX_GREEN-1`).
  - First clause is gap-out, second is max-out.
  - With no competing demand, GREEN holds indefinitely.
- YELLOW → CLEAR when `timer==YELLOW-1`.
- CLEAR exits when `timer==ALL_RED-1`:
  - if `ped_pend`, go to WALK; `owner` unchanged;
  - else go to GREEN with `owner <= ~owner`.
- WALK → GREEN when `timer==WALK-1`. Then `owner <= car_req[~owner] ? ~owner : owner`.
- `ped_pend`:
  - set on any cycle with `ped_req=1` outside WALK;
  - cleared on the edge that enters WALK (an entering-cycle `ped_req` is absorbed);
  - `ped_req` during WALK is ignored.
- Outputs (Moore, decoded from registered state only, no input-to-output paths):
  - GREEN: `green_light[owner]=1`, red on the other approach.
  - YELLOW: `yellow_light[owner]=1`, red on the other approach.
  - CLEAR/WALK: `red_light=2'b11`.
  - `walk=1` only in WALK.
  - Invariants: exactly one of R/Y/G is set per approach every cycle; never green on both approaches.
- Reset values:
  - state=GREEN, `owner=0`, `timer=0`, `ped_pend=0`;
  - `green_light=2'b01`, `yellow_light=2'b00`, `red_light=2'b10`, `walk=0`.

## Timing
- Decisions take effect on the clock edge where the condition holds. Outputs change on that same edge.
- A contested green is visible for at least MIN_GREEN and at most MAX_GREEN cycles. Yellow lasts exactly YELLOW cycles, clearance ALL_RED, walk WALK.
- Defaults, `car_req=2'b10` constant, released from reset at edge 0:
  - approach 0 green for edges 0–3;
  - yellow for 4–5;
  - all-red for 6;
  - approach 1 green from edge 7.
- Simultaneous `car_req` on both approaches: owner serves until MAX_GREEN, then alternates.
- Reset asserted mid-phase: all outputs go to reset values immediately (asynchronously) and `ped_pend` is lost.
- Timer width is `$clog2` of the largest parameter, +1 bit; no wrap is possible in any state.

## Structure
- Package `traffic_pkg`: state enum (2-bit encoding), approach index constants, light-vector width (2).
- Sub-module `phase_timer`: counter with synchronous clear-on-entry, optional saturate, and a terminal-compare input. Instantiated once.
- Top level holds the FSM, `owner`/`ped_pend` registers and output decode. Target size: ~150–250 lines RTL.

## Test plan
- Reset, then `car_req=2'b00`, no ped → green stays on approach 0 for 50 cycles; `red_light=2'b10` throughout.
- `car_req=2'b10` → approach 0 green exactly 4 cycles, yellow 2, all-red 1, then `green_light=2'b10`.
- `car_req=2'b11` constant → each green lasts 12 cycles, then alternates; yellow/clear order is preserved.
- 1-cycle `ped_req` pulse at cycle 2, `car_req=2'b00` → green ends at cycle 3, yellow 2, clear 1, `walk=1` for 6 cycles, then approach 0 green again. A `ped_req` during walk causes no second walk.
- Reset pulled low during YELLOW → outputs return to reset values in the same cycle; after release the normal sequence resumes from approach 0 green.
- Every cycle assertion: `green_light != 2'b11`, per-approach one-hot R/Y/G, `walk` implies `red_light=2'b11`.
